// File: rtl/toysram_scan_master.sv
// Scan initiator for the toysram test sites: turns a parallel shift request
// into test_enable / scan_clk / scan_di and captures scan_do into rx_data.
module toysram_scan_master #(
   parameter int unsigned DIV = 4
) (
   input  logic        clock,
   input  logic        resetb,
   input  logic        start,
   input  logic [5:0]  len,
   input  logic [31:0] tx_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] rx_data,
   output logic        test_enable,
   output logic        scan_clk,
   output logic        scan_di,
   input  logic        scan_do
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, TAIL} state_t;

   localparam logic [7:0] PHASE_LAST = 8'(DIV - 1);

   state_t      state_q, state_d;
   logic [7:0]  phase_q, phase_d;
   logic [5:0]  bit_q, bit_d;
   logic [5:0]  len_q, len_d;
   logic [30:0] tx_q, tx_d;
   logic [31:0] rx_q, rx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        sclk_q, sclk_d;
   logic        sdi_q, sdi_d;
   logic [1:0]  sync_q;
   logic        phase_last;

   assign phase_last = (phase_q == PHASE_LAST);

   always_comb begin
      // NOTE: every variable gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
      state_d = state_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      len_d   = len_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sclk_d  = sclk_q;
      sdi_d   = sdi_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOW;
               phase_d = '0;
               bit_d   = '0;
               len_d   = (len > 6'd32) ? 6'd32 : len;
               tx_d    = tx_data[31:1];
               rx_d    = '0;
               busy_d  = 1'b1;
               sclk_d  = 1'b0;
               sdi_d   = tx_data[0];
            end
         end

         LOW: begin
            phase_d = phase_q + 8'd1;
            if (phase_last) begin
               phase_d = '0;
               if (bit_q < len_q) begin
                  state_d = HIGH;
                  sclk_d  = 1'b1;
               end else begin
                  // Only reachable with a zero length: this low phase doubles as the tail.
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end

         HIGH: begin
            phase_d = phase_q + 8'd1;
            if (phase_last) begin
               phase_d            = '0;
               rx_d[bit_q[4:0]]   = sync_q[1];
               bit_d              = bit_q + 6'd1;
               tx_d               = tx_q >> 1;
               sclk_d             = 1'b0;
               if (bit_q + 6'd1 >= len_q) begin
                  state_d = TAIL;
               end else begin
                  state_d = LOW;
                  sdi_d   = tx_q[0];
               end
            end
         end

         TAIL: begin
            phase_d = phase_q + 8'd1;
            if (phase_last) begin
               phase_d = '0;
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q <= IDLE;
         phase_q <= '0;
         bit_q   <= '0;
         len_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         sdi_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values, like real flops.
         state_q <= state_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         len_q   <= len_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sclk_q  <= sclk_d;
         sdi_q   <= sdi_d;
      end
   end

   // scan_do is launched from the site's clock domain.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) sync_q <= '0;
      else         sync_q <= {sync_q[0], scan_do};
   end

   assign busy        = busy_q;
   assign test_enable = busy_q;
   assign done        = done_q;
   assign rx_data     = rx_q;
   assign scan_clk    = sclk_q;
   assign scan_di     = sdi_q;

endmodule

// File: tb/tb_toysram_scan_master.sv
// Self-checking bench for toysram_scan_master: scoreboarded transfers with a
// negedge monitor that counts scan_clk pulses, busy cycles and done pulses.
module tb_toysram_scan_master;

   localparam int DIV = 4;

   logic        clock = 1'b0;
   logic        resetb;
   logic        start;
   logic [5:0]  len;
   logic [31:0] tx_data;
   logic        busy;
   logic        done;
   logic [31:0] rx_data;
   logic        test_enable;
   logic        scan_clk;
   logic        scan_di;
   logic        scan_do;
   logic        loop_mode = 1'b0;
   logic        do_val = 1'b0;

   assign scan_do = loop_mode ? scan_di : do_val;

   always #5 clock = ~clock;

   toysram_scan_master #(.DIV(DIV)) dut (
      .clock       (clock),
      .resetb      (resetb),
      .start       (start),
      .len         (len),
      .tx_data     (tx_data),
      .busy        (busy),
      .done        (done),
      .rx_data     (rx_data),
      .test_enable (test_enable),
      .scan_clk    (scan_clk),
      .scan_di     (scan_di),
      .scan_do     (scan_do)
   );

   typedef struct {
      logic [31:0] rx;
      logic [31:0] bits;
      int          pulses;
      int          busy_cycles;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   // Monitor state, sampled on the falling edge.
   logic        prev_sclk = 1'b0;
   logic        prev_busy = 1'b0;
   logic        prev_di = 1'b0;
   int          rise_cnt = 0;
   int          busy_run = 0;
   int          di_high = 0;
   int          done_cnt = 0;
   int          glitch_cnt = 0;
   int          te_bad = 0;
   logic [31:0] seen = '0;

   always @(negedge clock) begin
      if (busy === 1'b1 && prev_busy !== 1'b1) begin
         rise_cnt <= 0;
         seen     <= '0;
         busy_run <= 1;
         di_high  <= (scan_di === 1'b1) ? 1 : 0;
      end else begin
         if (busy === 1'b1) busy_run <= busy_run + 1;
         if (busy === 1'b1 && scan_di === 1'b1) di_high <= di_high + 1;
         if (scan_clk === 1'b1 && prev_sclk !== 1'b1) begin
            if (rise_cnt < 32) seen[rise_cnt] <= scan_di;
            rise_cnt <= rise_cnt + 1;
         end
      end
      if (scan_clk === 1'b1 && prev_sclk === 1'b1 && scan_di !== prev_di) glitch_cnt <= glitch_cnt + 1;
      if (test_enable !== busy) te_bad <= te_bad + 1;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      prev_sclk <= scan_clk;
      prev_busy <= busy;
      prev_di   <= scan_di;
   end

   // One transfer: push expectation, pulse start, optionally re-pulse start
   // mid-transfer (poke >= 0), wait for done, pop and compare.
   task automatic do_xfer(input logic [31:0] tx, input logic [5:0] l, input logic lp,
                          input logic dv, input int poke, input bit tail_chk);
      exp_t        e;
      int          n;
      int          d0;
      int          g0;
      int          t0;
      bit          got;
      logic [31:0] m;
      n = (l > 6'd32) ? 32 : int'(l);
      m = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
      e.rx          = lp ? (tx & m) : (dv ? m : 32'h0);
      e.bits        = tx & m;
      e.pulses      = n;
      e.busy_cycles = DIV * (2 * n + 1);
      sb.push_back(e);

      loop_mode = lp;
      do_val    = dv;
      tx_data   = tx;
      len       = l;
      start     = 1'b1;
      d0 = done_cnt;
      g0 = glitch_cnt;
      t0 = te_bad;
      @(posedge clock);
      #1;
      start = 1'b0;
      total++;
      if ({busy, scan_di, scan_clk} !== {1'b1, tx[0], 1'b0}) begin
         bad++;
         $display("FAIL start_resp: got busy/di/sclk=%b want %b", {busy, scan_di, scan_clk}, {1'b1, tx[0], 1'b0});
      end

      got = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clock);
         #1;
         if (i == poke) begin
            start   = 1'b1;
            tx_data = 32'hFFFF_FFFF;
            len     = 6'd32;
         end else if (i == poke + 1) begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      start = 1'b0;
      e = sb.pop_front();
      total++;
      if (!got) begin
         bad++;
         $display("FAIL done_timeout: got no done want done within 2000 cycles");
         return;
      end

      total++;
      if (rx_data !== e.rx) begin
         bad++;
         $display("FAIL rx_data: got %h want %h", rx_data, e.rx);
      end
      total++;
      if (rise_cnt !== e.pulses) begin
         bad++;
         $display("FAIL pulses: got %0d want %0d", rise_cnt, e.pulses);
      end
      total++;
      if (busy_run !== e.busy_cycles) begin
         bad++;
         $display("FAIL busy_cycles: got %0d want %0d", busy_run, e.busy_cycles);
      end
      total++;
      if (seen !== e.bits) begin
         bad++;
         $display("FAIL tx_bits: got %h want %h", seen, e.bits);
      end
      total++;
      if (done_cnt - d0 !== 1) begin
         bad++;
         $display("FAIL done_count: got %0d want 1", done_cnt - d0);
      end
      total++;
      if (glitch_cnt - g0 !== 0 || te_bad - t0 !== 0) begin
         bad++;
         $display("FAIL di_stable_te: got glitches=%0d te_errs=%0d want 0 0", glitch_cnt - g0, te_bad - t0);
      end
      if (tx == 32'h0) begin
         total++;
         if (di_high !== 0) begin
            bad++;
            $display("FAIL di_low: got %0d high cycles want 0", di_high);
         end
      end
      if (tail_chk) begin
         @(negedge clock);
         #1;
         total++;
         if ({done, busy, rx_data} !== {1'b0, 1'b0, e.rx}) begin
            bad++;
            $display("FAIL after_done: got done=%b busy=%b rx=%h want 0 0 %h", done, busy, rx_data, e.rx);
         end
      end
   endtask

   task automatic test_reset;
      resetb  = 1'b0;
      start   = 1'b0;
      len     = '0;
      tx_data = '0;
      repeat (2) @(negedge clock);
      #1;
      total++;
      if ({busy, done, test_enable, scan_clk, scan_di, rx_data} !== 37'h0) begin
         bad++;
         $display("FAIL reset_state: got busy=%b done=%b te=%b sclk=%b di=%b rx=%h want all 0",
                  busy, done, test_enable, scan_clk, scan_di, rx_data);
      end
      resetb = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_loopback;
      do_xfer(32'hA5A5_0F0F, 6'd32, 1'b1, 1'b0, -1, 1'b1);
   endtask

   task automatic test_const_one;
      do_xfer(32'h0, 6'd5, 1'b0, 1'b1, -1, 1'b1);
   endtask

   task automatic test_len_bounds;
      do_xfer(32'h0000_0003, 6'd0, 1'b0, 1'b1, -1, 1'b1);
      do_xfer(32'hDEAD_BEEF, 6'd40, 1'b1, 1'b0, -1, 1'b1);
   endtask

   task automatic test_ignored_start;
      do_xfer(32'h0F0F_1234, 6'd32, 1'b1, 1'b0, 100, 1'b1);
   endtask

   task automatic test_back_to_back;
      do_xfer(32'h0000_0005, 6'd3, 1'b1, 1'b0, -1, 1'b0);
      do_xfer(32'h0000_CAFE, 6'd16, 1'b1, 1'b0, -1, 1'b1);
   endtask

   task automatic test_reset_mid;
      int d0;
      bit got;
      loop_mode = 1'b1;
      tx_data   = 32'h1234_5678;
      len       = 6'd32;
      start     = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clock);
         #1;
         if (rise_cnt == 10 && scan_clk === 1'b0) begin
            got = 1'b1;
            break;
         end
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL pulse10_timeout: got no 10th pulse want it within 500 cycles");
      end
      d0 = done_cnt;
      resetb = 1'b0;
      #1;
      total++;
      if ({scan_clk, test_enable, busy, scan_di, rx_data} !== 36'h0) begin
         bad++;
         $display("FAIL reset_mid: got sclk=%b te=%b busy=%b di=%b rx=%h want all 0",
                  scan_clk, test_enable, busy, scan_di, rx_data);
      end
      repeat (3) @(negedge clock);
      #1;
      resetb = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      total++;
      if (done_cnt - d0 !== 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL no_done_after_reset: got dones=%0d busy=%b want 0 0", done_cnt - d0, busy);
      end
      do_xfer(32'h8000_0001, 6'd32, 1'b1, 1'b0, -1, 1'b1);
   endtask

   initial begin
      resetb = 1'b0;
      start  = 1'b0;
      test_reset;
      test_loopback;
      test_const_one;
      test_len_bounds;
      test_ignored_start;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
